hls_register_arbiter: RTL and testbench
=======================================

# hls_register_arbiter

Write arbiter and sequencer for a bank of `hls_register` configuration registers shared by several HLS cores and the host control path. Each cycle it picks at most one pending write request by round-robin, registers the winning address/data, and drives a one-hot `write_en` plus common `write_data` into the register bank. An optional lock mechanism lets one requester hold the bank for an atomic multi-register update.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `NUM_REGS`, 8, number of registers in the bank (1..32)
- `WIDTH`, 32, register data width
- `ADDR_W`, `$clog2(NUM_REGS)` (min 1), register address width
- `LOCK_TIMEOUT`, 64, idle cycles before a held lock is forcibly released (lock build only)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  NUM_REQ*WIDTH  packed write data, same packing
- `req_lock`  in  NUM_REQ  hold grant after this transfer (lock build only)
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when valid & ready
- `reg_write_en`  out  NUM_REGS  one-hot write strobe to register bank
- `reg_write_data`  out  WIDTH  data for the strobed register
- `grant_id`  out  $clog2(NUM_REQ)  requester whose write is on `reg_write_en` this cycle
- `err_addr`  out  1  one-cycle pulse: accepted request had address >= NUM_REGS

## Operation
- Arbitration is combinational on `req_valid` and the priority pointer; `req_ready` is asserted only to the winner, and only when it is valid.
- Round-robin: search starts at `ptr`, wraps modulo NUM_REQ. On a transfer by requester k, `ptr` <= (k+1) mod NUM_REQ. With no transfer, `ptr` holds.
- Write stage: on a transfer, the next edge loads `reg_write_data` <= data and `grant_id` <= k, and sets `reg_write_en` one-hot at addr. With no transfer, `reg_write_en` is cleared at that edge and data/`grant_id` hold.
- Out-of-range address (possible only when NUM_REGS is not a power of two): the request is accepted and dropped. `reg_write_en` stays 0 and `err_addr` pulses for one cycle, aligned with where the strobe would have been.
- FSM (lock build): ARB and HOLD.
  - ARB: normal round-robin.
  - ARB -> HOLD on a transfer with `req_lock[k]`=1; owner <= k.
  - HOLD: only the owner can be granted; others see `req_ready`=0.
  - HOLD -> ARB on an owner transfer with `req_lock`=0 (that transfer is still written), or when the idle counter reaches LOCK_TIMEOUT.
  - The idle counter increments each HOLD cycle without an owner transfer and clears on any owner transfer.
  - On exit, `ptr` <= owner+1.
- Reset, asynchronous assert: `req_ready`=0, `reg_write_en`=0, `reg_write_data`=0, `grant_id`=0, `err_addr`=0, `ptr`=0, state ARB, idle counter 0. Any in-flight write stage is discarded.

## Timing
- Request accepted at edge E. `reg_write_en` is high during the cycle after E. The register captures at edge E+1 and `read_data` shows the new value after E+1. Total latency is 2 edges.
- Throughput is one write per cycle; back-to-back grants to different requesters are allowed.
- Simultaneous requests to the same address are serialized in round-robin order; the last one written wins.
- Timeout release takes effect at the edge the counter reaches LOCK_TIMEOUT. Arbitration in the following cycle is normal ARB.

## Configuration
- `HLS_REGISTER_ARB_LOCK_EN` defined: `req_lock` port, ARB/HOLD FSM, idle counter and LOCK_TIMEOUT are present.
- Undefined: `req_lock` port and the parameter are absent, and the block is pure round-robin (permanently in ARB).

## Structure
- Shared package `hls_register_pkg`: arbiter state enum (ARB, HOLD), default NUM_REQ/NUM_REGS/WIDTH, a `clog2_min1` function.
- One sub-module, `rr_priority_pick`: combinational round-robin picker taking `valid`, `ptr` and a mask, and returning one-hot `grant` and index. HOLD uses the mask to admit only the owner.

## Test plan
- Single requester 2 writes 0xDEADBEEF to addr 3: `req_ready[2]` high at accept; `reg_write_en`=0x08 and data 0xDEADBEEF one cycle later; `grant_id`=2.
- All 4 requesters valid continuously from reset: grants in order 0,1,2,3,0 on consecutive cycles; no gaps.
- NUM_REGS=6, write to addr 7: accepted; `err_addr` pulses one cycle; `reg_write_en` stays 0.
- Lock build: requester 1 writes with lock=1, then requesters 0 and 3 request. Only 1 is granted for 3 writes; after its lock=0 write, the next grant goes to 3 (ptr=2, so 3 precedes 0).
- Lock build: requester 1 locks, then idles. Release occurs exactly LOCK_TIMEOUT=64 cycles later, and requester 0 is granted the next cycle.
- `reset` asserted mid-burst while `reg_write_en` is high: all outputs go to 0 immediately (asynchronous). After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/hls_register_pkg.sv
// Shared types and helpers for the hls_register write arbiter.
// Optional lock build is selected by HLS_REGISTER_ARB_LOCK_EN in the top.
package hls_register_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_WIDTH    = 32;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hls_register_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first masked valid at or after ptr, wrapping.
module rr_priority_pick
    import hls_register_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] cand;

    always_comb begin
        cand  = valid & mask;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!any && cand[(int'(ptr) + off) % N]) begin
                any                          = 1'b1;
                grant[(int'(ptr) + off) % N] = 1'b1;
                idx                          = IW'((int'(ptr) + off) % N);
            end
        end
    end

endmodule

// File: rtl/hls_register_arbiter.sv
// Round-robin write arbiter/sequencer for the hls_register bank.
// Define HLS_REGISTER_ARB_LOCK_EN to add req_lock, the ARB/HOLD FSM and lock timeout.
module hls_register_arbiter
    import hls_register_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = clog2_min1(NUM_REGS)
`ifdef HLS_REGISTER_ARB_LOCK_EN
    ,
    parameter int LOCK_TIMEOUT = 64
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]         req_data,
`ifdef HLS_REGISTER_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_lock,
`endif
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REGS-1:0]              reg_write_en,
    output logic [WIDTH-1:0]                 reg_write_data,
    output logic [clog2_min1(NUM_REQ)-1:0]   grant_id,
    output logic                             err_addr
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam logic [ADDR_W:0] REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_any;
    logic [NUM_REQ-1:0]  base_mask;
    logic [NUM_REQ-1:0]  arb_mask;
    logic                xfer;
    logic                force_ptr_en;
    logic [IW-1:0]       force_ptr;

    logic [ADDR_W-1:0]   sel_addr;
    logic [WIDTH-1:0]    sel_data;
    logic                addr_bad;

    logic [NUM_REGS-1:0] wen_q, wen_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [IW-1:0]       gid_q, gid_d;
    logic                err_q, err_d;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
        return (k == IW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
    endfunction

    // Masking with reset keeps req_ready low while reset is held.
    assign arb_mask = reset ? base_mask : '0;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .mask  (arb_mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = pick_grant;
    assign xfer      = pick_any;

`ifdef HLS_REGISTER_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            owner_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        idle_d  = idle_q;
        timeout = 1'b0;
        case (state_q)
            ARB: begin
                if (xfer && req_lock[pick_idx]) begin
                    state_d = HOLD;
                    owner_d = pick_idx;
                    idle_d  = '0;
                end
            end
            HOLD: begin
                if (xfer) begin
                    idle_d = '0;
                    if (!req_lock[pick_idx]) state_d = ARB;
                end else if (idle_q == CW'(LOCK_TIMEOUT - 1)) begin
                    // Counter would reach LOCK_TIMEOUT on this edge: release now.
                    state_d = ARB;
                    idle_d  = '0;
                    timeout = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        base_mask = '1;
        if (state_q == HOLD) base_mask = NUM_REQ'(1) << owner_q;
    end

    assign force_ptr_en = timeout;
    assign force_ptr    = owner_q;
`else
    assign base_mask    = '1;
    assign force_ptr_en = 1'b0;
    assign force_ptr    = '0;
`endif

    always_comb begin
        sel_addr = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
        sel_data = req_data[int'(pick_idx) * WIDTH +: WIDTH];
        addr_bad = {1'b0, sel_addr} >= REGS_LIM;

        ptr_d = ptr_q;
        if (xfer)              ptr_d = next_idx(pick_idx);
        else if (force_ptr_en) ptr_d = next_idx(force_ptr);

        wen_d   = '0;
        err_d   = 1'b0;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (xfer) begin
            wdata_d = sel_data;
            gid_d   = pick_idx;
            err_d   = addr_bad;
            if (!addr_bad) wen_d = NUM_REGS'(1) << sel_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
        end
    end

    assign reg_write_en   = wen_q;
    assign reg_write_data = wdata_q;
    assign grant_id       = gid_q;
    assign err_addr       = err_q;

endmodule

// File: tb/tb_hls_register_arbiter.sv
// Scoreboard bench for hls_register_arbiter (NUM_REQ=4, NUM_REGS=6); lock tests run when
// HLS_REGISTER_ARB_LOCK_EN is defined.
module tb_hls_register_arbiter;

    localparam int NR = 4;
    localparam int NG = 6;
    localparam int W  = 32;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*W-1:0]   req_data;
`ifdef HLS_REGISTER_ARB_LOCK_EN
    logic [NR-1:0]     req_lock;
`endif
    logic [NR-1:0]     req_ready;
    logic [NG-1:0]     reg_write_en;
    logic [W-1:0]      reg_write_data;
    logic [1:0]        grant_id;
    logic              err_addr;

    logic [AW-1:0]     a_tab [NR];
    logic [W-1:0]      d_tab [NR];

    typedef struct {
        logic [NG-1:0] wen;
        logic [W-1:0]  data;
        logic [1:0]    gid;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hls_register_arbiter #(
        .NUM_REQ  (NR),
        .NUM_REGS (NG),
        .WIDTH    (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
`ifdef HLS_REGISTER_ARB_LOCK_EN
        .req_lock       (req_lock),
`endif
        .req_ready      (req_ready),
        .reg_write_en   (reg_write_en),
        .reg_write_data (reg_write_data),
        .grant_id       (grant_id),
        .err_addr       (err_addr)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a_tab[i];
            req_data[i*W +: W]   = d_tab[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge with inputs already driven; k = expected winner or -1.
    task automatic tick(input int k);
        exp_t e;
        exp_t o;
        #1;
        chk("req_ready", 64'(req_ready), (k < 0) ? 64'd0 : (64'd1 << k));
        if (k >= 0) begin
            e.err  = (a_tab[k] >= AW'(NG));
            e.wen  = e.err ? '0 : (NG'(1) << a_tab[k]);
            e.data = d_tab[k];
            e.gid  = 2'(k);
            sb.push_back(e);
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            o = sb.pop_front();
            chk("write_en", 64'(reg_write_en), 64'(o.wen));
            chk("err_addr", 64'(err_addr), 64'(o.err));
            if (!o.err) begin
                chk("write_data", 64'(reg_write_data), 64'(o.data));
                chk("grant_id", 64'(grant_id), 64'(o.gid));
            end
        end else begin
            chk("idle_write_en", 64'(reg_write_en), 64'd0);
            chk("idle_err_addr", 64'(err_addr), 64'd0);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_write_en", 64'(reg_write_en), 64'd0);
        chk("rst_write_data", 64'(reg_write_data), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '1;
`ifdef HLS_REGISTER_ARB_LOCK_EN
        req_lock = '0;
`endif
        for (int i = 0; i < NR; i++) begin
            a_tab[i] = '0;
            d_tab[i] = '0;
        end

        // Held in reset with every requester valid: nothing granted, outputs zero.
        @(negedge clk);
        #1;
        chk_reset_outputs();

        // Single requester 2 writes 0xDEADBEEF to addr 3.
        req_valid = 4'b0100;
        a_tab[2]  = 3'd3;
        d_tab[2]  = 32'hDEADBEEF;
        reset     = 1'b1;
        tick(2);
        req_valid = '0;
        tick(-1);

        // ptr=3: requester 3 to addr 6 (first out of range), then 0 to addr 5 (last in range).
        a_tab[3] = 3'd6; d_tab[3] = 32'h3333_0006;
        a_tab[0] = 3'd5; d_tab[0] = 32'h0000_0005;
        req_valid = 4'b1001;
        tick(3);
        req_valid = 4'b0001;
        tick(0);
        a_tab[1] = 3'd7; d_tab[1] = 32'h1111_0007;
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(-1);

        // ptr=2: two writes to the same address serialize 2 then 3.
        a_tab[2] = 3'd2; d_tab[2] = 32'h0000_AAAA;
        a_tab[3] = 3'd2; d_tab[3] = 32'h0000_BBBB;
        req_valid = 4'b1100;
        tick(2);
        req_valid = 4'b1000;
        tick(3);
        req_valid = '0;
        tick(-1);

        // All valid continuously from reset: 0,1,2,3,0,1 with no gaps.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_tab[i] = AW'(i);
            d_tab[i] = 32'h1000_0000 + 32'(i);
        end
        req_valid = '1;
        tick(0); tick(1); tick(2); tick(3); tick(0); tick(1);

        // Asynchronous reset while a write strobe is on the bank.
        chk("strobe_before_rst", 64'(reg_write_en), 64'h2);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        tick(0);
        tick(1);
        req_valid = '0;
        tick(-1);

`ifdef HLS_REGISTER_ARB_LOCK_EN
        // Lock by requester 1 blocks 0 and 3 across three owner writes.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        a_tab[0] = 3'd1; d_tab[0] = 32'hA0A0_0000;
        a_tab[1] = 3'd2; d_tab[1] = 32'hA1A1_1111;
        a_tab[3] = 3'd4; d_tab[3] = 32'hA3A3_3333;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        tick(1);
        req_valid = 4'b1011;
        tick(1);
        req_valid = 4'b1001;
        tick(-1);
        req_valid = 4'b1011;
        req_lock  = 4'b0000;
        tick(1);
        req_valid = 4'b1001;
        tick(3);
        req_valid = 4'b0001;
        tick(0);
        req_valid = '0;
        tick(-1);

        // Lock then idle: released exactly LOCK_TIMEOUT cycles later.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        tick(1);
        req_lock  = '0;
        req_valid = 4'b0001;
        repeat (64) tick(-1);
        tick(0);
        req_valid = '0;
        tick(-1);
`endif

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
